// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - length-prefixed byte stream to big-endian 32-bit instruction memory writes
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int          DEPTH     = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [7:0]       ByteIn,
  input  logic             ByteValid,
  output logic             ByteReady,
  output logic             MemWrite,
  output logic [31:0]      MemAddress,
  output logic [31:0]      MemWriteData,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] WordsWritten
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [23:0]      shift_q, shift_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             accept;
  logic [CNT_W-1:0] full_len;
  logic [CNT_W-1:0] words_inc;
  logic [31:0]      len_ext;

  assign accept    = ByteValid && ByteReady;
  assign full_len  = {len_q[CNT_W-1:8], ByteIn};
  assign words_inc = words_q + CNT_W'(1);
  assign len_ext   = 32'(full_len);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      words_q <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d = S_LEN_HI;
          words_d = '0;
          idx_d   = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d       = '0;
          len_d[15:8] = ByteIn;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = full_len;
          if (full_len == '0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else if (len_ext > 32'(DEPTH)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          idx_d   = idx_q + 2'd1;
          shift_d = {shift_q[15:0], ByteIn};
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ ByteIn;
`endif
          // Address and data are latched here so they are stable for the whole WRITE cycle.
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            wdata_d = {shift_q, ByteIn};
            addr_d  = BASE_ADDR + (32'(words_q) << 2);
          end
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        if (words_inc == len_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (accept) begin
          state_d = (ByteIn == csum_q) ? S_DONE : S_ERROR;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ByteReady    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
  assign MemWrite     = (state_q == S_WRITE);
  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;
  assign Busy         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign Done         = (state_q == S_DONE);
  assign Error        = (state_q == S_ERROR);
  assign WordsWritten = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
// Reference model derives expected writes and final status from the byte stream alone.
module tb_instr_mem_loader;

  localparam int          DEPTH = 512;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst, Start, ByteValid;
  logic [7:0]  ByteIn;
  logic        ByteReady, MemWrite, Busy, Done, Error;
  logic [31:0] MemAddress, MemWriteData;
  logic [15:0] WordsWritten;

  instr_mem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .MemWrite(MemWrite), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .Busy(Busy), .Done(Done), .Error(Error),
    .WordsWritten(WordsWritten)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [63:0] obs_q[$];
  int          obs_cyc[$];
  int          rdy_viol;
  always @(negedge Clk) begin
    if (MemWrite) begin
      obs_q.push_back({MemAddress, MemWriteData});
      obs_cyc.push_back(cyc);
      if (ByteReady) rdy_viol++;
    end
  end

  logic [7:0]  stim[$];
  int          acc_cyc[$];
  logic [63:0] exp_w[$];
  int          exp_idx[$];
  int          exp_st;

  task automatic do_reset();
    Rst = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic pulse_start();
    obs_q.delete(); obs_cyc.delete(); rdy_viol = 0;
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic drive(input int gap_pct, input int hold_idx, input int hold_len, input int glitch_idx);
    int i = 0;
    int guard = 0;
    int held = 0;
    bit acc;
    acc_cyc.delete();
    while (i < stim.size() && guard < 20000) begin
      guard++;
      ByteIn = stim[i];
      if (i == hold_idx && held < hold_len) begin
        ByteValid = 1'b0;
        held++;
      end else begin
        ByteValid = ($urandom_range(0, 99) >= gap_pct);
      end
      Start = (i == glitch_idx);
      acc = ByteValid && ByteReady;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge Clk);
      if (acc) i++;
      @(negedge Clk);
    end
    ByteValid = 1'b0;
    Start = 1'b0;
  endtask

  // Expected writes: word k is stream bytes 2+4k..2+4k+3, big-endian, at BASE+4k.
  task automatic run_model();
    int len;
    logic [7:0] x;
    exp_w.delete(); exp_idx.delete();
    len = int'({stim[0], stim[1]});
    x = 8'h00;
    if (len > DEPTH) begin
      exp_st = 2;
    end else begin
      for (int k = 0; k < len; k++) begin
        exp_w.push_back({BASE + 32'(4 * k),
                         stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]});
        exp_idx.push_back(5 + 4 * k);
        x = x ^ stim[2+4*k] ^ stim[3+4*k] ^ stim[4+4*k] ^ stim[5+4*k];
      end
      if (CSUM) exp_st = (stim[2+4*len] == x) ? 1 : 2;
      else      exp_st = 1;
    end
  endtask

  task automatic make_stream(input int len, input bit good_csum);
    logic [7:0] b, x;
    stim.delete();
    x = 8'h00;
    stim.push_back(8'(len >> 8));
    stim.push_back(8'(len));
    if (len <= DEPTH) begin
      for (int i = 0; i < 4 * len; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        stim.push_back(b);
      end
      if (CSUM) stim.push_back(good_csum ? x : ~x);
    end
  endtask

  task automatic check_load(input string tag);
    int n = 0;
    int m;
    run_model();
    while (!(Done || Error) && n < 50) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (Done !== (exp_st == 1)) begin
      errors++; $display("FAIL %s done: got %b expected %b", tag, Done, exp_st == 1);
    end
    checks++;
    if (Error !== (exp_st == 2)) begin
      errors++; $display("FAIL %s error: got %b expected %b", tag, Error, exp_st == 2);
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("FAIL %s busy: got %b expected 0", tag, Busy);
    end
    checks++;
    if (WordsWritten !== 16'(exp_w.size())) begin
      errors++; $display("FAIL %s words_written: got %0d expected %0d", tag, WordsWritten, exp_w.size());
    end
    checks++;
    if (obs_q.size() != exp_w.size()) begin
      errors++; $display("FAIL %s write_count: got %0d expected %0d", tag, obs_q.size(), exp_w.size());
    end
    m = (obs_q.size() < exp_w.size()) ? obs_q.size() : exp_w.size();
    for (int k = 0; k < m; k++) begin
      checks++;
      if (obs_q[k] !== exp_w[k]) begin
        errors++; $display("FAIL %s write[%0d] addr/data: got %h expected %h", tag, k, obs_q[k], exp_w[k]);
      end
      if (exp_idx[k] < acc_cyc.size()) begin
        checks++;
        if (obs_cyc[k] != acc_cyc[exp_idx[k]] + 1) begin
          errors++; $display("FAIL %s write[%0d] latency: got cycle %0d expected %0d",
                             tag, k, obs_cyc[k], acc_cyc[exp_idx[k]] + 1);
        end
      end
    end
    checks++;
    if (rdy_viol != 0) begin
      errors++; $display("FAIL %s ready_in_write: got %0d expected 0", tag, rdy_viol);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ByteReady, MemWrite, Busy, Done, Error} !== 5'b0) begin
      errors++; $display("FAIL reset flags: got %b expected 00000", {ByteReady, MemWrite, Busy, Done, Error});
    end
    checks++;
    if (MemAddress !== BASE || MemWriteData !== 32'h0 || WordsWritten !== 16'h0) begin
      errors++; $display("FAIL reset values: got %h/%h/%0d expected %h/0/0", MemAddress, MemWriteData, WordsWritten, BASE);
    end
  endtask

  task automatic test_single_word();
    stim = '{8'h00, 8'h01, 8'h8C, 8'h08, 8'h00, 8'h04};
    if (CSUM) stim.push_back(8'h8C ^ 8'h08 ^ 8'h00 ^ 8'h04);
    pulse_start();
    checks++;
    if (Busy !== 1'b1 || ByteReady !== 1'b1) begin
      errors++; $display("FAIL single start busy/ready: got %b%b expected 11", Busy, ByteReady);
    end
    drive(0, -1, 0, -1);
    check_load("single");
    checks++;
    if (obs_q.size() > 0 && obs_q[0] !== {32'h0000_0000, 32'h8C08_0004}) begin
      errors++; $display("FAIL single word: got %h expected 000000008c080004", obs_q[0]);
    end
  endtask

  task automatic test_gapped_words();
    make_stream(3, 1'b1);
    pulse_start();
    drive(20, 7, 3, 4);
    check_load("gapped");
  endtask

  task automatic test_oversize();
    stim = '{8'h02, 8'h01};
    pulse_start();
    drive(0, -1, 0, -1);
    check_load("oversize");
    pulse_start();
    checks++;
    if (Error !== 1'b0 || Busy !== 1'b1) begin
      errors++; $display("FAIL restart after error: got err=%b busy=%b expected 0/1", Error, Busy);
    end
    make_stream(2, 1'b1);
    drive(10, -1, 0, -1);
    check_load("after_error");
  endtask

  task automatic test_zero_len();
    stim = '{8'h00, 8'h00};
    if (CSUM) stim.push_back(8'h00);
    pulse_start();
    drive(0, -1, 0, -1);
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("FAIL zero_len immediate done: got %b expected 1", Done);
    end
    check_load("zero_len");
  endtask

  task automatic test_mid_reset();
    stim = '{8'h00, 8'h02, 8'hA5, 8'h5A};
    pulse_start();
    drive(0, -1, 0, -1);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if ({ByteReady, MemWrite, Busy, Done, Error} !== 5'b0 || WordsWritten !== 16'h0) begin
      errors++; $display("FAIL mid_reset flags: got %b/%0d expected 00000/0", {ByteReady, MemWrite, Busy, Done, Error}, WordsWritten);
    end
    checks++;
    if (MemAddress !== BASE || MemWriteData !== 32'h0) begin
      errors++; $display("FAIL mid_reset regs: got %h/%h expected %h/0", MemAddress, MemWriteData, BASE);
    end
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL mid_reset writes: got %0d expected 0", obs_q.size());
    end
    make_stream(2, 1'b1);
    pulse_start();
    drive(25, -1, 0, -1);
    check_load("after_reset");
  endtask

  task automatic test_random_loads();
    for (int t = 0; t < 6; t++) begin
      make_stream($urandom_range(1, 9), 1'b1);
      pulse_start();
      drive($urandom_range(0, 40), -1, 0, -1);
      check_load("random");
    end
    make_stream(DEPTH, 1'b1);
    pulse_start();
    drive(0, -1, 0, -1);
    check_load("full_depth");
    checks++;
    if (obs_q.size() != DEPTH || obs_q[obs_q.size()-1][63:32] !== BASE + 32'(4 * (DEPTH - 1))) begin
      errors++; $display("FAIL full_depth last addr: got %0d writes expected %0d ending at %h",
                         obs_q.size(), DEPTH, BASE + 32'(4 * (DEPTH - 1)));
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    pulse_start();
    drive(0, -1, 0, -1);
    check_load("csum_good");
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("FAIL csum_good done: got %b expected 1", Done);
    end
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    pulse_start();
    drive(0, -1, 0, -1);
    check_load("csum_bad");
    checks++;
    if (Error !== 1'b1 || obs_q.size() != 1 || obs_q[0][31:0] !== 32'h1234_5678) begin
      errors++; $display("FAIL csum_bad: got err=%b writes=%0d expected 1/1 word 12345678", Error, obs_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_gapped_words();
    test_oversize();
    test_zero_len();
    test_mid_reset();
    test_random_loads();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
